// File: rtl/gpr_bank_pkg.sv
// Shared types and defaults for the general-purpose register bank.
// Latency: none (declarations only).
// Backpressure: none.
package gpr_bank_pkg;

    localparam int GPR_DATA_W = 16;
    localparam int GPR_ADDR_W = 3;

    typedef enum logic {
        GPR_IDLE  = 1'b0,
        GPR_CLEAR = 1'b1
    } gpr_state_t;

    // LSB of field idx in a packed per-port bus of width-bit fields.
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/gpr_bank_if.sv
// Bundle of read/write/clear signals between decode (master) and the register bank (slave).
// Latency: none (wiring only).
// Backpressure: busy from the slave marks writes as dropped.
interface gpr_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
) ();
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     clr_req;
    logic                     busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/gpr_bank_read_port.sv
// One registered read port with optional write-first forwarding (GPR_BYPASS_EN).
// Latency: 1 cycle from rd_en to rd_valid/rd_data.
// Backpressure: none; data holds while rd_en is low.
module gpr_bank_read_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_mem_dat,
    input  logic              i_wr_vld,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_clr_vld,
    input  logic [ADDR_W-1:0] i_clr_addr,
    output logic [DATA_W-1:0] o_rd_dat,
    output logic              o_rd_vld
);
    logic [DATA_W-1:0] w_rd_dat;
    logic [DATA_W-1:0] r_rd_dat;
    logic              r_rd_vld;

`ifdef GPR_BYPASS_EN
    // Write and clear never coexist (writes are dropped while clearing).
    always_comb begin
        w_rd_dat = i_mem_dat;
        if (i_clr_vld && (i_clr_addr == i_rd_addr)) begin
            w_rd_dat = '0;
        end else if (i_wr_vld && (i_wr_addr == i_rd_addr)) begin
            w_rd_dat = i_wr_dat;
        end
    end
`else
    assign w_rd_dat = i_mem_dat;
    wire w_unused = ^{i_wr_vld, i_wr_addr, i_wr_dat, i_clr_vld, i_clr_addr};
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= i_rd_en;
            if (i_rd_en) begin
                r_rd_dat <= w_rd_dat;
            end
        end
    end

    assign o_rd_dat = r_rd_dat;
    assign o_rd_vld = r_rd_vld;
endmodule

// File: rtl/gpr_bank.sv
// Register bank: 2**ADDR_W x DATA_W storage, NUM_RD read ports, one write port, sequenced clear.
// Latency: reads 1 cycle; clear takes 2**ADDR_W cycles. Bypass selected by GPR_BYPASS_EN.
// Backpressure: busy high during clear; writes are dropped, reads still served.
module gpr_bank
    import gpr_bank_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic       i_clock,
    input  logic       i_reset,
    gpr_bank_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    gpr_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic              w_wr_acc;
    logic              w_clearing;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;

    assign w_clearing = (r_state == GPR_CLEAR);
    assign w_wr_acc   = bus.wr_en && !w_clearing;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state   <= GPR_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_mem[bus.wr_addr] <= bus.wr_data;
            end
            case (r_state)
                GPR_IDLE: begin
                    if (bus.clr_req) begin
                        r_state <= GPR_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                GPR_CLEAR: begin
                    r_mem[r_clr_cnt] <= '0;
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state   <= GPR_IDLE;
                        r_busy    <= 1'b0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= GPR_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = bus.rd_addr[field_lsb(g, ADDR_W) +: ADDR_W];

        gpr_bank_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_rd_en    (bus.rd_en[g]),
            .i_rd_addr  (w_addr),
            .i_mem_dat  (r_mem[w_addr]),
            .i_wr_vld   (w_wr_acc),
            .i_wr_addr  (bus.wr_addr),
            .i_wr_dat   (bus.wr_data),
            .i_clr_vld  (w_clearing),
            .i_clr_addr (r_clr_cnt),
            .o_rd_dat   (w_rd_data[field_lsb(g, DATA_W) +: DATA_W]),
            .o_rd_vld   (bus.rd_valid[g])
        );
    end

    assign bus.rd_data = w_rd_data;
    assign bus.busy    = r_busy;
endmodule
